// File: rtl/jedro_1_alu_pkg.sv
// -----------------------------------------------------------------------------
// jedro_1_alu_pkg
// Shared definitions for the jedro_1 sequential ALU:
//   - ALU_OP_WIDTH and the ALU_OP_* opcode constants ({funct7[5], funct3})
//   - alu_state_e : FSM states of the sequential ALU
//   - shift_dir_e : direction select for the serial shifter
//   - is_shift_op : true for SLL / SRL / SRA
// -----------------------------------------------------------------------------
package jedro_1_alu_pkg;

  localparam int ALU_OP_WIDTH = 4;

  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_ADD  = 4'b0000;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SUB  = 4'b1000;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SLL  = 4'b0001;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SLT  = 4'b0010;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SLTU = 4'b0011;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_XOR  = 4'b0100;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SRL  = 4'b0101;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SRA  = 4'b1101;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_OR   = 4'b0110;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_AND  = 4'b0111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } alu_state_e;

  typedef enum logic {
    SHIFT_LEFT  = 1'b0,
    SHIFT_RIGHT = 1'b1
  } shift_dir_e;

  function automatic logic is_shift_op(input logic [ALU_OP_WIDTH-1:0] op);
    return (op == ALU_OP_SLL) || (op == ALU_OP_SRL) || (op == ALU_OP_SRA);
  endfunction

endpackage

// File: rtl/jedro_1_seq_alu_if.sv
// -----------------------------------------------------------------------------
// jedro_1_seq_alu_if
// Operand-side and result-side handshake bundle of the sequential ALU.
//   master : producer/consumer side (decode/operand-fetch and writeback)
//   slave  : the ALU itself
// Signals:
//   in_valid_i   operands and opcode valid
//   in_ready_o   ALU can accept an operation this cycle
//   alu_op_sel_i operation select
//   opa_i/opb_i  operands; shift amount is opb_i[$clog2(DATA_WIDTH)-1:0]
//   res_valid_o  res_o holds a completed result
//   res_ready_i  consumer accepts the result
//   res_o        registered result
//   busy_o       serial shift in progress
// -----------------------------------------------------------------------------
interface jedro_1_seq_alu_if
  import jedro_1_alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) ();

  logic                    in_valid_i;
  logic                    in_ready_o;
  logic [ALU_OP_WIDTH-1:0] alu_op_sel_i;
  logic [DATA_WIDTH-1:0]   opa_i;
  logic [DATA_WIDTH-1:0]   opb_i;
  logic                    res_valid_o;
  logic                    res_ready_i;
  logic [DATA_WIDTH-1:0]   res_o;
  logic                    busy_o;

  modport master (
    output in_valid_i, alu_op_sel_i, opa_i, opb_i, res_ready_i,
    input  in_ready_o, res_valid_o, res_o, busy_o
  );

  modport slave (
    input  in_valid_i, alu_op_sel_i, opa_i, opb_i, res_ready_i,
    output in_ready_o, res_valid_o, res_o, busy_o
  );

endinterface

// File: rtl/jedro_1_serial_shifter.sv
// -----------------------------------------------------------------------------
// jedro_1_serial_shifter
// Iterative shifter: shifts a loaded value by up to SHIFT_STEP bits per cycle
// until the loaded amount is consumed.
// Ports:
//   clk       rising-edge clock
//   load      capture data/amount/direction/arith (overrides any shift)
//   data      value to shift
//   amount    total shift distance
//   direction SHIFT_LEFT or SHIFT_RIGHT
//   arith     right shifts replicate data's sign bit
//   done      the current cycle performs the final step
//   result    value after the current cycle's step (valid with done)
// -----------------------------------------------------------------------------
module jedro_1_serial_shifter
  import jedro_1_alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic                          clk,
  input  logic                          load,
  input  logic [DATA_WIDTH-1:0]         data,
  input  logic [$clog2(DATA_WIDTH)-1:0] amount,
  input  shift_dir_e                    direction,
  input  logic                          arith,
  output logic                          done,
  output logic [DATA_WIDTH-1:0]         result
);

  localparam int                AMT_W = $clog2(DATA_WIDTH);
  localparam logic [AMT_W-1:0]  STEP  = AMT_W'(SHIFT_STEP);

  logic [DATA_WIDTH-1:0]   value_q;
  logic [AMT_W-1:0]        remaining_q;
  logic                    sign_q;
  shift_dir_e              dir_q;
  logic [AMT_W-1:0]        step_amt;
  logic [2*DATA_WIDTH-1:0] right_wide;
  logic [DATA_WIDTH-1:0]   shifted;

  // The last step may be shorter than SHIFT_STEP.
  assign step_amt = (remaining_q < STEP) ? remaining_q : STEP;

  // The captured sign (zero for logical shifts) fills from the top on every
  // step, so SRA always replicates the original operand's sign bit.
  assign right_wide = {{DATA_WIDTH{sign_q}}, value_q} >> step_amt;
  assign shifted    = (dir_q == SHIFT_RIGHT) ? right_wide[DATA_WIDTH-1:0]
                                             : (value_q << step_amt);

  assign done   = (remaining_q <= STEP);
  assign result = shifted;

  // NOTE: pure datapath registers carry no reset; they are always written by
  // load before the controller looks at done/result.
  always_ff @(posedge clk) begin
    if (load) begin
      value_q     <= data;
      remaining_q <= amount;
      sign_q      <= arith & data[DATA_WIDTH-1];
      dir_q       <= direction;
    end else if (remaining_q != '0) begin
      value_q     <= shifted;
      remaining_q <= remaining_q - step_amt;
    end
  end

endmodule

// File: rtl/jedro_1_seq_alu.sv
// -----------------------------------------------------------------------------
// jedro_1_seq_alu
// Multi-cycle execute-stage ALU with valid/ready on operand and result sides.
// Non-shift ops complete in one cycle; shifts go through the serial shifter
// (ceil(shamt/SHIFT_STEP)+1 cycles). The result is held until writeback takes
// it, and a new op may be accepted in the same cycle the old result leaves.
// Ports:
//   clk_i  rising-edge clock
//   rst_i  synchronous, active-high reset
//   bus    jedro_1_seq_alu_if.slave handshake/data bundle
// -----------------------------------------------------------------------------
module jedro_1_seq_alu
  import jedro_1_alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  jedro_1_seq_alu_if.slave  bus
);

  localparam int AMT_W = $clog2(DATA_WIDTH);

  alu_state_e              state_q, state_d;
  logic [DATA_WIDTH-1:0]   res_q, res_d;
  logic                    res_load;
  logic                    in_ready;
  logic                    accept;

  logic [ALU_OP_WIDTH-1:0] op;
  logic [DATA_WIDTH-1:0]   opa, opb;
  logic [AMT_W-1:0]        shamt;
  logic                    launch_shift;

  logic                    is_sub;
  logic [DATA_WIDTH-1:0]   addend, sum, alu_result;

  logic                    sh_load, sh_done, sh_arith;
  shift_dir_e              sh_dir;
  logic [DATA_WIDTH-1:0]   sh_result;

  assign op    = bus.alu_op_sel_i;
  assign opa   = bus.opa_i;
  assign opb   = bus.opb_i;
  assign shamt = opb[AMT_W-1:0];

  assign in_ready = (state_q == IDLE) || ((state_q == DONE) && bus.res_ready_i);
  assign accept   = bus.in_valid_i && in_ready;

  // A zero-distance shift needs no iteration: alu_result already holds opa.
  assign launch_shift = is_shift_op(op) && (shamt != '0);

  // ---------------------------------------------------------------------------
  // Single-cycle datapath. SUB shares the adder as A + ~B + 1.
  // ---------------------------------------------------------------------------
  always_comb begin
    is_sub     = (op == ALU_OP_SUB);
    addend     = is_sub ? ~opb : opb;
    sum        = opa + addend + DATA_WIDTH'(is_sub);
    alu_result = '0;
    unique case (op)
      ALU_OP_ADD,
      ALU_OP_SUB:  alu_result = sum;
      ALU_OP_SLT:  alu_result = DATA_WIDTH'($signed(opa) < $signed(opb));
      ALU_OP_SLTU: alu_result = DATA_WIDTH'(opa < opb);
      ALU_OP_XOR:  alu_result = opa ^ opb;
      ALU_OP_OR:   alu_result = opa | opb;
      ALU_OP_AND:  alu_result = opa & opb;
      ALU_OP_SLL,
      ALU_OP_SRL,
      ALU_OP_SRA:  alu_result = opa;
      default:     alu_result = '0;
    endcase
  end

  assign sh_dir   = ((op == ALU_OP_SRL) || (op == ALU_OP_SRA)) ? SHIFT_RIGHT : SHIFT_LEFT;
  assign sh_arith = (op == ALU_OP_SRA);

  jedro_1_serial_shifter #(
    .DATA_WIDTH (DATA_WIDTH),
    .SHIFT_STEP (SHIFT_STEP)
  ) u_shifter (
    .clk       (clk_i),
    .load      (sh_load),
    .data      (opa),
    .amount    (shamt),
    .direction (sh_dir),
    .arith     (sh_arith),
    .done      (sh_done),
    .result    (sh_result)
  );

  // ---------------------------------------------------------------------------
  // FSM next-state / result-load logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    res_d    = res_q;
    res_load = 1'b0;
    sh_load  = 1'b0;

    unique case (state_q)
      IDLE:    ;
      SHIFT: begin
        if (sh_done) begin
          res_d    = sh_result;
          res_load = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (bus.res_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // accept is only possible from IDLE or from a DONE that is being drained,
    // so it overrides the per-state decision above.
    if (accept) begin
      if (launch_shift) begin
        sh_load = 1'b1;
        state_d = SHIFT;
      end else begin
        res_d    = alu_result;
        res_load = 1'b1;
        state_d  = DONE;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      if (res_load) res_q <= res_d;
    end
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.res_valid_o = (state_q == DONE);
  assign bus.res_o       = res_q;
  assign bus.busy_o      = (state_q == SHIFT);

endmodule

// File: tb/tb_jedro_1_seq_alu.sv
// -----------------------------------------------------------------------------
// tb_jedro_1_seq_alu
// Self-checking bench: a cycle monitor compares the DUT against an in-order
// behavioural model (result value, latency, hold and handshake behaviour);
// directed cases pin literal results and latencies; a random stream with
// random valid gaps and result stalls exercises ordering and back-pressure.
// A second instance with SHIFT_STEP = 4 covers multi-bit shift steps.
// -----------------------------------------------------------------------------
module tb_jedro_1_seq_alu;
  import jedro_1_alu_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  jedro_1_seq_alu_if #(.DATA_WIDTH(W)) bus ();
  jedro_1_seq_alu_if #(.DATA_WIDTH(W)) bus4 ();

  jedro_1_seq_alu #(.DATA_WIDTH(W), .SHIFT_STEP(1)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  jedro_1_seq_alu #(.DATA_WIDTH(W), .SHIFT_STEP(4)) dut4 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus4.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    int unsigned sh;
    sh = b % 32;
    case (op)
      ALU_OP_ADD:  return a + b;
      ALU_OP_SUB:  return a - b;
      ALU_OP_SLL:  return a << sh;
      ALU_OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
      ALU_OP_XOR:  return a ^ b;
      ALU_OP_SRL:  return a >> sh;
      ALU_OP_SRA:  return $signed(a) >>> sh;
      ALU_OP_OR:   return a | b;
      ALU_OP_AND:  return a & b;
      default:     return 32'd0;
    endcase
  endfunction

  function automatic int ref_latency(input logic [3:0] op, input logic [31:0] b, input int step);
    int sh;
    sh = int'(b % 32);
    if ((op == ALU_OP_SLL || op == ALU_OP_SRL || op == ALU_OP_SRA) && sh != 0)
      return (sh + step - 1) / step + 1;
    return 1;
  endfunction

  // ---------------------------------------------------------------------------
  // Cycle monitor (step-1 instance): one op in flight at most
  // ---------------------------------------------------------------------------
  bit          inflight = 1'b0;
  int          cyc = 0, start_cyc = 0, exp_lat = 0, mon_age = 0;
  int          n_acc = 0, n_res = 0;
  logic [31:0] exp_res = '0, last_res = '0;
  bit          exp_valid, exp_ready;

  always @(negedge clk) begin
    if (rst) begin
      inflight = 1'b0;
      last_res = '0;
      n_acc    = 0;
      n_res    = 0;
    end else begin
      if (inflight) begin
        mon_age   = cyc - start_cyc;
        exp_valid = (mon_age >= exp_lat);
        exp_ready = exp_valid && bus.res_ready_i;
        check("mon_res_valid", 32'(bus.res_valid_o), 32'(exp_valid));
        check("mon_busy", 32'(bus.busy_o), 32'(!exp_valid));
        if (exp_valid) check("mon_res", bus.res_o, exp_res);
        else           check("mon_res_hold", bus.res_o, last_res);
        if (exp_valid && bus.res_ready_i) begin
          inflight = 1'b0;
          last_res = exp_res;
          n_res++;
        end
      end else begin
        exp_ready = 1'b1;
        check("mon_idle_valid", 32'(bus.res_valid_o), 32'd0);
        check("mon_idle_busy", 32'(bus.busy_o), 32'd0);
        check("mon_idle_res_hold", bus.res_o, last_res);
      end
      check("mon_in_ready", 32'(bus.in_ready_o), 32'(exp_ready));
      if (bus.in_valid_i && bus.in_ready_o) begin
        inflight  = 1'b1;
        start_cyc = cyc;
        exp_lat   = ref_latency(bus.alu_op_sel_i, bus.opb_i, 1);
        exp_res   = ref_result(bus.alu_op_sel_i, bus.opa_i, bus.opb_i);
        n_acc++;
      end
    end
    cyc++;
  end

  // ---------------------------------------------------------------------------
  // Drivers (called at posedge + 1)
  // ---------------------------------------------------------------------------
  // Presents an op and holds it until accepted; returns at posedge+1 after the
  // accepting edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bit ok;
    ok               = 1'b0;
    bus.alu_op_sel_i = op;
    bus.opa_i        = a;
    bus.opb_i        = b;
    bus.in_valid_i   = 1'b1;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      if (bus.in_ready_o) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.in_valid_i = 1'b0;
    if (!ok) check("issue_timeout", 32'd0, 32'd1);
  endtask

  // Directed op on the step-1 instance with res_ready high.
  task automatic run_dir(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input int el, input string name);
    int          lat, busy_cnt;
    logic [31:0] res;
    lat = 0; busy_cnt = 0; res = '0;
    bus.res_ready_i = 1'b1;
    issue(op, a, b);
    for (int k = 1; k <= 60 && lat == 0; k++) begin
      @(negedge clk);
      if (bus.busy_o) busy_cnt++;
      if (bus.res_valid_o) begin
        lat = k;
        res = bus.res_o;
      end
    end
    check({name, "_res"}, res, er);
    check({name, "_lat"}, 32'(lat), 32'(el));
    check({name, "_busy"}, 32'(busy_cnt), 32'(el - 1));
    @(posedge clk);
    #1;
  endtask

  // Directed op on the step-4 instance.
  task automatic run_step4(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] er, input int el, input string name);
    int          lat;
    logic [31:0] res;
    lat = 0; res = '0;
    bus4.alu_op_sel_i = op;
    bus4.opa_i        = a;
    bus4.opb_i        = b;
    bus4.res_ready_i  = 1'b1;
    bus4.in_valid_i   = 1'b1;
    @(negedge clk);
    check({name, "_accept"}, 32'(bus4.in_ready_o), 32'd1);
    @(posedge clk);
    #1;
    bus4.in_valid_i = 1'b0;
    for (int k = 1; k <= 60 && lat == 0; k++) begin
      @(negedge clk);
      if (bus4.res_valid_o) begin
        lat = k;
        res = bus4.res_o;
      end
    end
    check({name, "_res"}, res, er);
    check({name, "_lat"}, 32'(lat), 32'(el));
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  logic [3:0] valid_ops [10] = '{ALU_OP_ADD, ALU_OP_SUB, ALU_OP_SLL, ALU_OP_SLT, ALU_OP_SLTU,
                                 ALU_OP_XOR, ALU_OP_SRL, ALU_OP_SRA, ALU_OP_OR, ALU_OP_AND};
  logic [31:0] specials [6] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h8000_0000,
                                32'h7FFF_FFFF, 32'h0000_0001, 32'h0000_001F};
  bit stream_done = 1'b0;

  function automatic logic [31:0] rand_operand();
    if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  initial begin
    bus.in_valid_i    = 1'b0;
    bus.res_ready_i   = 1'b1;
    bus.alu_op_sel_i  = '0;
    bus.opa_i         = '0;
    bus.opb_i         = '0;
    bus4.in_valid_i   = 1'b0;
    bus4.res_ready_i  = 1'b1;
    bus4.alu_op_sel_i = '0;
    bus4.opa_i        = '0;
    bus4.opb_i        = '0;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_res_valid", 32'(bus.res_valid_o), 32'd0);
    check("rst_res", bus.res_o, 32'd0);
    check("rst_in_ready", 32'(bus.in_ready_o), 32'd1);
    check("rst_busy", 32'(bus.busy_o), 32'd0);
    @(posedge clk);
    #1;

    // Directed literal cases
    run_dir(ALU_OP_ADD,  32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 1, "add_wrap");
    run_dir(ALU_OP_SUB,  32'd5,         32'd7,         32'hFFFF_FFFE, 1, "sub_neg");
    run_dir(ALU_OP_SLT,  32'hFFFF_FFFF, 32'd1,         32'd1,         1, "slt");
    run_dir(ALU_OP_SLTU, 32'hFFFF_FFFF, 32'd1,         32'd0,         1, "sltu");
    run_dir(4'b1001,     32'h1234_5678, 32'h9ABC_DEF0, 32'd0,         1, "bad_op");
    run_dir(ALU_OP_SRA,  32'h8000_0000, 32'h0000_0104, 32'hF800_0000, 5, "sra4");
    run_dir(ALU_OP_SRL,  32'h8000_0000, 32'h0000_0104, 32'h0800_0000, 5, "srl4");
    run_dir(ALU_OP_SLL,  32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 1, "sll0");
    run_dir(ALU_OP_SLL,  32'h0000_0003, 32'hFFFF_FFE1, 32'h0000_0006, 2, "sll1_hi_ignored");
    run_dir(ALU_OP_OR,   32'hF000_000F, 32'h0F00_00F0, 32'hFF00_00FF, 1, "or");

    // Multi-bit shift steps
    run_step4(ALU_OP_SLL, 32'h8000_0000, 32'd31, 32'h0000_0000, 9, "s4_sll31");
    run_step4(ALU_OP_SRA, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 9, "s4_sra31");
    run_step4(ALU_OP_SRL, 32'h8000_0000, 32'd6,  32'h0200_0000, 3, "s4_srl6");

    // Back-pressure: AND result held for 3 cycles, then XOR issued as it drains
    bus.res_ready_i = 1'b0;
    issue(ALU_OP_AND, 32'hF0F0_F0F0, 32'h3C3C_3C3C);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(bus.res_valid_o), 32'd1);
      check("bp_res", bus.res_o, 32'h3030_3030);
      check("bp_in_ready", 32'(bus.in_ready_o), 32'd0);
      @(posedge clk);
      #1;
    end
    bus.res_ready_i  = 1'b1;
    bus.alu_op_sel_i = ALU_OP_XOR;
    bus.opa_i        = 32'h1234_5678;
    bus.opb_i        = 32'hFFFF_0000;
    bus.in_valid_i   = 1'b1;
    @(negedge clk);
    check("bp_drain_accept", 32'(bus.in_ready_o), 32'd1);
    @(posedge clk);
    #1 bus.in_valid_i = 1'b0;
    @(negedge clk);
    check("bp_next_valid", 32'(bus.res_valid_o), 32'd1);
    check("bp_next_res", bus.res_o, 32'hEDCB_5678);
    @(posedge clk);
    #1;

    // Reset in the 2nd SHIFT cycle of SLL by 10
    issue(ALU_OP_SLL, 32'h0000_0001, 32'd10);
    @(posedge clk);
    #1;
    check("mid_rst_busy_before", 32'(bus.busy_o), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", 32'(bus.busy_o), 32'd0);
    check("mid_rst_valid", 32'(bus.res_valid_o), 32'd0);
    check("mid_rst_res", bus.res_o, 32'd0);
    check("mid_rst_in_ready", 32'(bus.in_ready_o), 32'd1);
    @(posedge clk);
    #1;
    run_dir(ALU_OP_ADD, 32'd100, 32'd23, 32'd123, 1, "post_rst_add");

    // Random stream with random input gaps and result stalls
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          logic [3:0]  op;
          logic [31:0] a, b;
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          if ($urandom_range(0, 11) < 10) op = valid_ops[$urandom_range(0, 9)];
          else                            op = 4'($urandom);
          a = rand_operand();
          b = rand_operand();
          if ($urandom_range(0, 7) == 0) b = b & 32'hFFFF_FFE0;
          issue(op, a, b);
        end
        stream_done = 1'b1;
      end
      begin
        while (!stream_done) begin
          bus.res_ready_i = ($urandom_range(0, 3) != 0);
          @(posedge clk);
          #1;
        end
      end
    join

    bus.res_ready_i = 1'b1;
    for (int t = 0; t < 100 && inflight; t++) @(negedge clk);
    check("drain_empty", 32'(inflight), 32'd0);
    check("one_result_per_op", 32'(n_res), 32'(n_acc));
    check("stream_accepts", 32'(n_acc >= 300), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
